// File: rtl/inst_mem_responder.sv
// Instruction-side memory responder: fetch requests read a synchronous SRAM, and the words
// return in order through a response FIFO with an optional per-response wait (INST_RESP_RAND_DELAY_EN).
module inst_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int RESP_DEPTH = 4,
  parameter int LATENCY    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc,
  input  logic                  Inst_Req_Valid,
  output logic                  Inst_Req_Ready,
  output logic [31:0]           Instruction,
  output logic                  Inst_Valid,
  input  logic                  Inst_Ready,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int OW = $clog2(RESP_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  logic [31:0]   fifo [RESP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] count;
  logic [OW-1:0] occ;
  logic          rd_pending;
  state_t        state;
  state_t        state_next;
  logic [4:0]    cnt;
  logic [4:0]    cnt_next;
  logic [4:0]    load_wait;
  logic          fire;
  logic          push;
  logic          pop;

  // Ready depends only on registered credit so Inst_Ready never reaches it combinationally.
  assign Inst_Req_Ready = ~rst & (occ != OW'(RESP_DEPTH));
  assign fire           = Inst_Req_Valid & Inst_Req_Ready;
  assign mem_ren        = fire;
  assign mem_addr       = rst ? {ADDR_WIDTH{1'b0}} : pc[ADDR_WIDTH+1:2];
  assign push           = rd_pending;
  assign pop            = (state == PRESENT) & Inst_Ready;

`ifdef INST_RESP_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign load_wait = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
  assign load_wait = 5'(LATENCY);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      occ        <= '0;
      state      <= IDLE;
      cnt        <= 5'd0;
    end else begin
      rd_pending <= fire;
      state      <= state_next;
      cnt        <= cnt_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
      case ({fire, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= mem_rdata;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (push) begin
          if (load_wait != 5'd0) begin
            state_next = WAIT;
            cnt_next   = load_wait;
          end else begin
            state_next = PRESENT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        cnt_next = cnt - 5'd1;
        if (cnt == 5'd1) begin
          state_next = PRESENT;
        end else begin
          state_next = WAIT;
        end
      end
      PRESENT: begin
        // A word being written this cycle counts as the next head.
        if (pop) begin
          if ((count > OW'(1)) || push) begin
            if (load_wait != 5'd0) begin
              state_next = WAIT;
              cnt_next   = load_wait;
            end else begin
              state_next = PRESENT;
            end
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = PRESENT;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 5'd0;
      end
    endcase
  end

  always_comb begin
    if (state == PRESENT) begin
      Inst_Valid  = 1'b1;
      Instruction = fifo[rd_ptr];
    end else begin
      Inst_Valid  = 1'b0;
      Instruction = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench for inst_mem_responder: directed scenarios plus random traffic,
// checked against a queue-based model of outstanding fetches.
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] instr;
  logic        valid;
  logic        inst_ready = 1'b0;
  logic        ren;
  logic [9:0]  addr;
  logic [31:0] rdata;

  logic [31:0] pc3 = 32'h0;
  logic        v3 = 1'b0;
  logic        rr3;
  logic [31:0] instr3;
  logic        val3;
  logic        r3 = 1'b0;
  logic        ren3;
  logic [9:0]  addr3;
  logic [31:0] rdata3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dut_fires = 0;
  int dut_pops = 0;
  logic [31:0] exp_q[$];
  int          due_q[$];

  always #5 clk = ~clk;

  inst_mem_responder #(.ADDR_WIDTH(10), .RESP_DEPTH(4), .LATENCY(0)) dut (
    .clk(clk), .rst(rst), .pc(pc), .Inst_Req_Valid(req_valid), .Inst_Req_Ready(req_ready),
    .Instruction(instr), .Inst_Valid(valid), .Inst_Ready(inst_ready),
    .mem_ren(ren), .mem_addr(addr), .mem_rdata(rdata)
  );

  inst_mem_responder #(.ADDR_WIDTH(10), .RESP_DEPTH(4), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .pc(pc3), .Inst_Req_Valid(v3), .Inst_Req_Ready(rr3),
    .Instruction(instr3), .Inst_Valid(val3), .Inst_Ready(r3),
    .mem_ren(ren3), .mem_addr(addr3), .mem_rdata(rdata3)
  );

  function automatic logic [31:0] word_of(input logic [9:0] idx);
    if (idx == 10'd4) return 32'h0000_0013;
    return {22'h0, idx} * 32'h9E37_79B1 + 32'h0000_0101;
  endfunction

  // Synchronous SRAM models: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (ren) rdata <= word_of(addr);
    if (ren3) rdata3 <= word_of(addr3);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: compare the DUT against the model, advance the model, move to the next negedge.
  task automatic step();
    logic       exp_ready;
    logic       exp_valid;
    logic [9:0] idx;
    #1;
    idx = pc[11:2];
    exp_ready = ~rst & (exp_q.size() != 4);
    chk("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
    chk("mem_ren", {31'h0, ren}, {31'h0, req_valid & exp_ready});
    if (req_valid & req_ready) dut_fires++;
    if (valid & inst_ready) dut_pops++;
    if (rst) begin
      chk("mem_addr_rst", {22'h0, addr}, 32'h0);
      exp_q.delete();
      due_q.delete();
    end else begin
      exp_valid = (exp_q.size() > 0) && (due_q[0] <= cyc);
      chk("inst_valid", {31'h0, valid}, {31'h0, exp_valid});
      if (req_valid) chk("mem_addr", {22'h0, addr}, {22'h0, idx});
      if (exp_valid) begin
        chk("instruction", instr, exp_q[0]);
        if (inst_ready) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
      if (req_valid & exp_ready) begin
        exp_q.push_back(word_of(idx));
        due_q.push_back(cyc + 2);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;

    // Reset values in the first cycle after reset
    #1;
    chk("rst_instruction", instr, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    step();

    // Single fetch of word 4
    req_valid = 1'b1; pc = 32'h0000_0010; inst_ready = 1'b1;
    #1;
    chk("single_ren", {31'h0, ren}, 32'h1);
    chk("single_addr", {22'h0, addr}, 32'd4);
    step();
    req_valid = 1'b0;
    step();
    #1;
    chk("single_valid_t2", {31'h0, valid}, 32'h1);
    chk("single_word_t2", instr, 32'h0000_0013);
    step();
    idle(3);

    // Address wrap above ADDR_WIDTH+1
    req_valid = 1'b1; pc = 32'h0000_1004;
    #1;
    chk("wrap_addr", {22'h0, addr}, 32'd1);
    step();
    idle(4);

    // Streaming 16 back-to-back fetches
    dut_fires = 0; dut_pops = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; pc = 32'(i * 4);
      step();
    end
    idle(5);
    chk("stream_fires", dut_fires, 32'd16);
    chk("stream_pops", dut_pops, 32'd16);

    // Backpressure: only RESP_DEPTH requests accepted
    dut_fires = 0; inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; pc = 32'h100 + 32'(i * 4);
      step();
    end
    chk("bp_fires", dut_fires, 32'd4);
    req_valid = 1'b0;
    #1;
    chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
    chk("bp_hold_word", instr, word_of(10'h040));
    inst_ready = 1'b1;
    idle(8);

    // Reset with three queued entries and one read pending
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; pc = 32'h200 + 32'(i * 4);
      step();
    end
    req_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, valid}, 32'h0);
    chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    step();
    inst_ready = 1'b1; req_valid = 1'b1; pc = 32'h0000_0040;
    step();
    idle(5);

    // LATENCY=3 instance: valid at T+5, held until taken
    v3 = 1'b1; pc3 = 32'h0000_0020;
    #1;
    chk("lat3_ren", {31'h0, ren3}, 32'h1);
    chk("lat3_addr", {22'h0, addr3}, 32'd8);
    step();
    v3 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("lat3_not_yet", {31'h0, val3}, 32'h0);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lat3_valid", {31'h0, val3}, 32'h1);
      chk("lat3_word", instr3, word_of(10'd8));
      step();
    end
    r3 = 1'b1;
    #1;
    chk("lat3_pop_valid", {31'h0, val3}, 32'h1);
    step();
    r3 = 1'b0;
    #1;
    chk("lat3_after_pop", {31'h0, val3}, 32'h0);
    step();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      pc         = $urandom;
      step();
    end
    inst_ready = 1'b1;
    idle(10);
    #1;
    chk("drain_valid", {31'h0, valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
